// File: rtl/host_cmd_master.sv
// Host command initiator: serializes WR/RD/ALU requests into UART frame bytes and collects the response.
// First TX byte one cycle after accept; RSP_VALID two cycles after the final handshake; TX waits on TX_READY.
module host_cmd_master #(
    parameter int RSP_TIMEOUT = 50000,
    parameter int CNT_W       = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [1:0]  REQ_OPCODE,
    input  logic [3:0]  REQ_ADDR,
    input  logic [7:0]  REQ_DATA,
    input  logic [7:0]  REQ_OPB,
    input  logic [3:0]  REQ_FUN,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic [15:0] RSP_DATA,
    output logic        RSP_VALID,
    output logic        RSP_TOUT,
    output logic        BUSY,
    output logic [7:0]  STRAY_CNT
);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_LO, WAIT_HI, DONE} state_t;

    typedef struct packed {
        logic [1:0] opcode;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] opb;
        logic [3:0] fun;
    } req_t;

    localparam logic [1:0] OP_WR  = 2'd0;
    localparam logic [1:0] OP_RD  = 2'd1;
    localparam logic [1:0] OP_ALU = 2'd2;
    localparam logic [1:0] OP_NOP = 2'd3;

    localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(RSP_TIMEOUT - 1);

    function automatic logic [7:0] frame_byte(input req_t r, input logic [1:0] i);
        logic [7:0] b;
        b = 8'h00;
        case (r.opcode)
            OP_WR: begin
                case (i)
                    2'd0:    b = 8'hAA;
                    2'd1:    b = {4'h0, r.addr};
                    default: b = r.data;
                endcase
            end
            OP_RD: b = (i == 2'd0) ? 8'hBB : {4'h0, r.addr};
            OP_ALU: begin
                case (i)
                    2'd0:    b = 8'hCC;
                    2'd1:    b = r.data;
                    2'd2:    b = r.opb;
                    default: b = {4'h0, r.fun};
                endcase
            end
            default: b = (i == 2'd0) ? 8'hDD : {4'h0, r.fun};
        endcase
        return b;
    endfunction

    function automatic logic [1:0] last_idx(input logic [1:0] op);
        logic [1:0] n;
        case (op)
            OP_WR:   n = 2'd2;
            OP_ALU:  n = 2'd3;
            default: n = 2'd1;
        endcase
        return n;
    endfunction

    state_t           state_q, state_d;
    req_t             req_q, req_in;
    logic [1:0]       idx_q;
    logic [7:0]       tx_data_q;
    logic             tx_valid_q;
    logic [15:0]      rsp_data_q;
    logic             rsp_valid_q, rsp_tout_q;
    logic [7:0]       stray_q;
    logic [CNT_W-1:0] cnt_q;

    logic req_fire, tx_fire, last_byte, wait_st, tout_hit;

    assign req_in = '{opcode: REQ_OPCODE, addr: REQ_ADDR, data: REQ_DATA, opb: REQ_OPB, fun: REQ_FUN};

    always_comb begin
        state_d   = state_q;
        req_fire  = (state_q == IDLE) && REQ_VALID;
        tx_fire   = (state_q == SEND) && tx_valid_q && TX_READY;
        last_byte = (idx_q == last_idx(req_q.opcode));
        wait_st   = (state_q == WAIT_LO) || (state_q == WAIT_HI);
        // A response byte arriving on the final count still completes the request
        tout_hit  = wait_st && !RX_VALID && (cnt_q == TOUT_LAST);
        case (state_q)
            IDLE:    if (req_fire) state_d = SEND;
            SEND: begin
                if (tx_fire && last_byte)
                    state_d = (req_q.opcode == OP_WR) ? DONE : WAIT_LO;
            end
            WAIT_LO: begin
                if (RX_VALID)
                    state_d = (req_q.opcode == OP_RD) ? DONE : WAIT_HI;
                else if (tout_hit)
                    state_d = IDLE;
            end
            WAIT_HI: begin
                if (RX_VALID)      state_d = DONE;
                else if (tout_hit) state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            req_q       <= '0;
            idx_q       <= 2'd0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_valid_q <= 1'b0;
            rsp_tout_q  <= 1'b0;
            stray_q     <= 8'h00;
            cnt_q       <= '0;
        end else begin
            rsp_valid_q <= (state_q == DONE);
            rsp_tout_q  <= tout_hit;
            if (RX_VALID && !wait_st && (stray_q != 8'hFF))
                stray_q <= stray_q + 8'd1;

            if (req_fire) begin
                req_q      <= req_in;
                idx_q      <= 2'd0;
                tx_valid_q <= 1'b1;
                tx_data_q  <= frame_byte(req_in, 2'd0);
            end

            if (tx_fire) begin
                if (last_byte) begin
                    tx_valid_q <= 1'b0;
                    tx_data_q  <= 8'h00;
                    cnt_q      <= '0;
                    if (req_q.opcode == OP_WR)
                        rsp_data_q <= 16'h0000;
                end else begin
                    idx_q     <= idx_q + 2'd1;
                    tx_data_q <= frame_byte(req_q, idx_q + 2'd1);
                end
            end

            if (wait_st) begin
                if (RX_VALID) begin
                    cnt_q <= '0;
                    if (state_q == WAIT_LO) begin
                        rsp_data_q[7:0] <= RX_DATA;
                        if (req_q.opcode == OP_RD)
                            rsp_data_q[15:8] <= 8'h00;
                    end else begin
                        rsp_data_q[15:8] <= RX_DATA;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign REQ_READY = (state_q == IDLE);
    assign BUSY      = (state_q != IDLE);
    assign TX_DATA   = tx_data_q;
    assign TX_VALID  = tx_valid_q;
    assign RSP_DATA  = rsp_data_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_TOUT  = rsp_tout_q;
    assign STRAY_CNT = stray_q;

endmodule

// File: tb/tb_host_cmd_master.sv
// Randomized bench for host_cmd_master against a frame/response reference model.
module tb_host_cmd_master;

    localparam int TOUT = 10;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic [1:0]  REQ_OPCODE = 2'd0;
    logic [3:0]  REQ_ADDR = 4'h0;
    logic [7:0]  REQ_DATA = 8'h00;
    logic [7:0]  REQ_OPB = 8'h00;
    logic [3:0]  REQ_FUN = 4'h0;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY = 1'b0;
    logic [7:0]  RX_DATA = 8'h00;
    logic        RX_VALID = 1'b0;
    logic [15:0] RSP_DATA;
    logic        RSP_VALID;
    logic        RSP_TOUT;
    logic        BUSY;
    logic [7:0]  STRAY_CNT;

    host_cmd_master #(.RSP_TIMEOUT(TOUT), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OPCODE(REQ_OPCODE),
        .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .REQ_OPB(REQ_OPB), .REQ_FUN(REQ_FUN),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .RSP_DATA(RSP_DATA), .RSP_VALID(RSP_VALID), .RSP_TOUT(RSP_TOUT),
        .BUSY(BUSY), .STRAY_CNT(STRAY_CNT)
    );

    always #5 CLK = ~CLK;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] exp_rsp = 16'h0000;
    int          exp_stray = 0;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic stray_pulse();
        RX_VALID = 1'b1;
        RX_DATA  = 8'($urandom);
        exp_stray = (exp_stray < 255) ? exp_stray + 1 : 255;
    endtask

    task automatic run_txn(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] data,
                           input logic [7:0] opb, input logic [3:0] fun,
                           input int d_lo, input int d_hi, input logic [7:0] b_lo, input logic [7:0] b_hi,
                           input int stall_pct, input int stray_pct);
        logic [7:0] exp_b[4];
        int         exp_n, nrx, sent, cyc, waited, d;
        bit         tr, tout;
        logic [7:0] b;

        // Reference frame built straight from the opcode table
        exp_b = '{8'h00, 8'h00, 8'h00, 8'h00};
        case (op)
            2'd0: begin exp_b[0] = 8'hAA; exp_b[1] = {4'h0, addr}; exp_b[2] = data; exp_n = 3; nrx = 0; end
            2'd1: begin exp_b[0] = 8'hBB; exp_b[1] = {4'h0, addr}; exp_n = 2; nrx = 1; end
            2'd2: begin exp_b[0] = 8'hCC; exp_b[1] = data; exp_b[2] = opb; exp_b[3] = {4'h0, fun}; exp_n = 4; nrx = 2; end
            default: begin exp_b[0] = 8'hDD; exp_b[1] = {4'h0, fun}; exp_n = 2; nrx = 2; end
        endcase

        chk("req_ready", REQ_READY, 1);
        REQ_VALID = 1'b1; REQ_OPCODE = op; REQ_ADDR = addr; REQ_DATA = data; REQ_OPB = opb; REQ_FUN = fun;
        step();
        REQ_VALID = 1'b0;
        REQ_OPCODE = 2'($urandom); REQ_ADDR = 4'($urandom); REQ_DATA = 8'($urandom);
        REQ_OPB = 8'($urandom); REQ_FUN = 4'($urandom);
        chk("busy_send", BUSY, 1);
        chk("ready_busy", REQ_READY, 0);

        sent = 0; cyc = 0;
        while (sent < exp_n) begin
            chk("tx_vld", TX_VALID, 1);
            chk("tx_dat", TX_DATA, exp_b[sent]);
            tr = ($urandom_range(99) >= stall_pct);
            TX_READY = tr;
            if ($urandom_range(99) < stray_pct) stray_pulse();
            step();
            RX_VALID = 1'b0; TX_READY = 1'b0;
            if (tr) sent++;
            cyc++;
            if (cyc > 500) begin chk("tx_bound", 0, 1); break; end
        end
        chk("tx_drop", TX_VALID, 0);
        chk("stray", STRAY_CNT, 16'(exp_stray));

        tout = 0;
        for (int k = 0; k < nrx && !tout; k++) begin
            d = (k == 0) ? d_lo : d_hi;
            b = (k == 0) ? b_lo : b_hi;
            waited = 0;
            while (1) begin
                if (waited == d) begin
                    RX_VALID = 1'b1; RX_DATA = b;
                    step();
                    RX_VALID = 1'b0;
                    break;
                end
                step();
                waited++;
                if (waited == TOUT) begin tout = 1; break; end
                chk("no_tout", RSP_TOUT, 0);
            end
            if (!tout) begin
                if (k == 0) begin
                    exp_rsp[7:0] = b;
                    if (op == 2'd1) exp_rsp[15:8] = 8'h00;
                end else begin
                    exp_rsp[15:8] = b;
                end
            end
        end
        if (op == 2'd0) exp_rsp = 16'h0000;

        if (tout) begin
            chk("tout_pulse", RSP_TOUT, 1);
            chk("tout_no_vld", RSP_VALID, 0);
            chk("tout_ready", REQ_READY, 1);
            chk("tout_rsp", RSP_DATA, exp_rsp);
            step();
            chk("tout_once", RSP_TOUT, 0);
            chk("tout_no_vld2", RSP_VALID, 0);
        end else begin
            chk("vld_early", RSP_VALID, 0);
            chk("busy_done", BUSY, 1);
            step();
            chk("rsp_vld", RSP_VALID, 1);
            chk("rsp_dat", RSP_DATA, exp_rsp);
            chk("rsp_tout0", RSP_TOUT, 0);
            chk("ready_back", REQ_READY, 1);
            step();
            chk("rsp_once", RSP_VALID, 0);
            chk("rsp_hold", RSP_DATA, exp_rsp);
        end
        chk("idle", BUSY, 0);
    endtask

    initial begin
        repeat (3) step();
        RST = 1'b0;
        chk("rst_ready", REQ_READY, 1);
        chk("rst_txv", TX_VALID, 0);
        chk("rst_txd", TX_DATA, 0);
        chk("rst_rsp", RSP_DATA, 0);
        chk("rst_rspv", RSP_VALID, 0);
        chk("rst_tout", RSP_TOUT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_stray", STRAY_CNT, 0);

        run_txn(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 0, 0, 8'h00, 8'h00, 0, 0);
        run_txn(2'd1, 4'hA, 8'h00, 8'h00, 4'h0, 3, 0, 8'h77, 8'h00, 50, 0);
        run_txn(2'd2, 4'h0, 8'h12, 8'h34, 4'h2, 0, 2, 8'hF8, 8'h03, 0, 0);
        run_txn(2'd3, 4'h0, 8'h00, 8'h00, 4'h1, 1, 4, 8'h5A, 8'hA5, 0, 0);
        run_txn(2'd1, 4'h6, 8'h00, 8'h00, 4'h0, TOUT, 0, 8'h00, 8'h00, 0, 0);
        run_txn(2'd1, 4'h7, 8'h00, 8'h00, 4'h0, TOUT - 1, 0, 8'h9C, 8'h00, 0, 0);
        run_txn(2'd2, 4'h0, 8'h01, 8'h02, 4'h3, 2, TOUT, 8'h44, 8'h00, 0, 0);
        run_txn(2'd0, 4'h9, 8'hE1, 8'h00, 4'h0, 0, 0, 8'h00, 8'h00, 30, 100);

        for (int t = 0; t < 40; t++) begin
            logic [1:0] op;
            int dl, dh;
            op = 2'($urandom);
            dl = ($urandom_range(7) == 0) ? TOUT : $urandom_range(TOUT - 1);
            dh = ($urandom_range(7) == 0) ? TOUT : $urandom_range(TOUT - 1);
            if ($urandom_range(3) == 0) begin
                stray_pulse();
                step();
                RX_VALID = 1'b0;
            end
            run_txn(op, 4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                    dl, dh, 8'($urandom), 8'($urandom), 40, 20);
        end

        REQ_VALID = 1'b1; REQ_OPCODE = 2'd2; REQ_DATA = 8'h12; REQ_OPB = 8'h34; REQ_FUN = 4'h2;
        step();
        REQ_VALID = 1'b0;
        TX_READY = 1'b1;
        step();
        step();
        chk("mid_byte", TX_DATA, 16'h0034);
        RST = 1'b1; TX_READY = 1'b0;
        step();
        RST = 1'b0;
        chk("mrst_txv", TX_VALID, 0);
        chk("mrst_busy", BUSY, 0);
        chk("mrst_ready", REQ_READY, 1);
        chk("mrst_stray", STRAY_CNT, 0);
        chk("mrst_rsp", RSP_DATA, 0);
        exp_stray = 0;
        exp_rsp = 16'h0000;
        run_txn(2'd1, 4'h3, 8'h00, 8'h00, 4'h0, 2, 0, 8'h21, 8'h00, 0, 0);

        for (int i = 0; i < 300; i++) begin
            stray_pulse();
            step();
        end
        RX_VALID = 1'b0;
        chk("stray_sat", STRAY_CNT, 16'(exp_stray));
        chk("stray_sat_abs", STRAY_CNT, 16'd255);
        chk("stray_idle", BUSY, 0);
        chk("stray_ready", REQ_READY, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/host_cmd_master.md
Name: host_cmd_master

Overview:
- Host-side command initiator for the UART register/ALU command protocol (opcodes 0xAA write, 0xBB read, 0xCC ALU op, 0xDD ALU no-op).
- Accepts one request at a time and serializes it into command frame bytes on a byte-stream TX interface feeding a UART transmitter.
- Collects the 1- or 2-byte response from a UART receiver and returns it with a completion or timeout pulse.
- Sits in the host/testbench-side controller, opposite the system controller.

Parameters:
- RSP_TIMEOUT, 50000, consecutive wait-state cycles without RX_VALID before a request is aborted (legal range 2..2^CNT_W-1).
- CNT_W, 16, width of the timeout counter.

Ports:
- CLK  in  1  system clock, all logic on posedge
- RST  in  1  reset, synchronous, active-high
- REQ_VALID  in  1  request valid
- REQ_READY  out  1  request accepted when REQ_VALID && REQ_READY at posedge
- REQ_OPCODE  in  2  0=WR, 1=RD, 2=ALU_OP, 3=ALU_NOP
- REQ_ADDR  in  4  register address (WR/RD)
- REQ_DATA  in  8  write data (WR) / operand A (ALU_OP)
- REQ_OPB  in  8  operand B (ALU_OP)
- REQ_FUN  in  4  ALU function (ALU_OP/ALU_NOP)
- TX_DATA  out  8  frame byte to UART TX
- TX_VALID  out  1  TX_DATA valid
- TX_READY  in  1  UART TX accepts byte when TX_VALID && TX_READY
- RX_DATA  in  8  received byte from UART RX
- RX_VALID  in  1  one-cycle pulse, RX_DATA valid
- RSP_DATA  out  16  response: RD={8'h00,byte}, ALU={hi,lo}, WR=16'h0000
- RSP_VALID  out  1  one-cycle completion pulse
- RSP_TOUT  out  1  one-cycle timeout pulse
- BUSY  out  1  high in any state other than IDLE
- STRAY_CNT  out  8  saturating count of RX_VALID pulses received outside wait states

Behaviour:
- Reset (synchronous, active-high) applies at any posedge with RST=1, including mid-frame:
  - State goes to IDLE and the frame is abandoned.
  - TX_VALID=0, TX_DATA=0, RSP_DATA=0, RSP_VALID=0, RSP_TOUT=0, BUSY=0, STRAY_CNT=0, timeout counter=0.
  - REQ_READY=1 in the first cycle after reset.
- States: IDLE, SEND, WAIT_LO, WAIT_HI, DONE.
- IDLE:
  - REQ_READY=1.
  - On accept, all REQ_* fields are registered and the byte index is set to 0; go to SEND.
  - REQ_* inputs are don't-care after the accept edge.
- Frames (byte 0 first):
  - WR: AA, {4'h0,ADDR}, DATA (length 3)
  - RD: BB, {4'h0,ADDR} (length 2)
  - ALU_OP: CC, DATA, OPB, {4'h0,FUN} (length 4)
  - ALU_NOP: DD, {4'h0,FUN} (length 2)
- SEND:
  - TX_VALID=1 and TX_DATA=current byte, both from registers; the first byte is valid in the cycle after accept.
  - TX_DATA is stable while TX_VALID=1 and TX_READY=0.
  - Each handshake advances the index; the next byte is presented in the following cycle with no bubble.
  - On the handshake of the last byte, TX_VALID drops next cycle.
    - WR goes to DONE.
    - RD, ALU_OP and ALU_NOP go to WAIT_LO with the timeout counter cleared.
- WAIT_LO:
  - On RX_VALID, RSP_DATA[7:0]=RX_DATA.
    - RD: RSP_DATA[15:8]=0, go to DONE.
    - ALU: go to WAIT_HI with the counter cleared.
- WAIT_HI: on RX_VALID, RSP_DATA[15:8]=RX_DATA, go to DONE.
- DONE:
  - RSP_VALID=1 for exactly one cycle, then IDLE. For WR, RSP_DATA=16'h0000.
  - RSP_DATA holds until the next completion or reset.
  - Completion latency: RSP_VALID is high in the cycle after DONE is entered, i.e. 2 cycles after the final TX handshake (WR) or the final RX_VALID edge.
- Timeout:
  - The counter increments on each wait-state cycle without RX_VALID.
  - When it reaches RSP_TIMEOUT, go to IDLE, pulse RSP_TOUT for one cycle, and leave RSP_VALID low.
  - RSP_DATA keeps any low byte already captured.
  - If RX_VALID arrives in the same cycle the counter would reach RSP_TIMEOUT, RX_VALID wins.
- Stray bytes:
  - RX_VALID in IDLE, SEND or DONE is dropped; STRAY_CNT increments and saturates at 255.
  - RX_VALID during SEND does not shorten the frame.
- Back-to-back: REQ_READY returns 1 the cycle after DONE or timeout; no other request queuing.
- TX_READY is ignored when TX_VALID=0.

Test Plan:
- WR: ADDR=4'h5, DATA=8'h3C, TX_READY=1 -> TX bytes AA,05,3C on 3 consecutive cycles; RSP_VALID 2 cycles after the last handshake; RSP_DATA=0000; no RX needed.
- RD with TX_READY toggling 1/0: ADDR=4'hA -> bytes BB,0A each held stable through stalls; RX 8'h77 -> RSP_DATA=0077, one RSP_VALID pulse.
- ALU_OP: A=8'h12, B=8'h34, FUN=4'h2 -> bytes CC,12,34,02; RX 8'hF8 then 8'h03 -> RSP_DATA=03F8. ALU_NOP with FUN=4'h1 -> DD,01, same 2-byte collection.
- Timeout with RSP_TIMEOUT=10: RD with no RX -> RSP_TOUT pulse exactly 10 wait cycles after entering WAIT_LO, no RSP_VALID, REQ_READY=1 next cycle. Separately, RX_VALID on the 10th cycle completes normally.
- Stray and saturation: 300 RX_VALID pulses in IDLE -> STRAY_CNT=255, state still IDLE. One RX_VALID during SEND -> STRAY_CNT+1 and frame bytes unchanged.
- Reset mid-frame: RST=1 after the second ALU_OP byte handshake -> next cycle TX_VALID=0, BUSY=0, REQ_READY=1. A new RD request after release sends BB,addr cleanly.
